// File: rtl/trap_sequencer.sv
// Supervisor trap sequencer: arbitrates exception/SRET/interrupt, drains the pipeline,
// writes sepc/scause and offers a redirect PC to fetch over valid/ready.
module trap_sequencer #(
  parameter int          FLUSH_CYCLES = 2,
  parameter logic [11:0] CSR_SEPC     = 12'h141,
  parameter logic [11:0] CSR_SCAUSE   = 12'h142
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_valid,
  input  logic [31:0] exc_cause,
  input  logic [63:0] exc_pc,
  input  logic        irq_pending,
  input  logic [63:0] irq_pc,
  input  logic        sret_valid,
  input  logic [63:0] stvec,
  input  logic [63:0] sepc_in,
  output logic        flush,
  output logic        stall,
  output logic        busy,
  output logic        csr_we,
  output logic [11:0] csr_addr,
  output logic [63:0] csr_wdata,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc,
  input  logic        redirect_ready,
  output logic        sie
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DRAIN    = 3'd1,
    WR_EPC   = 3'd2,
    WR_CAUSE = 3'd3,
    REDIRECT = 3'd4
  } state_t;

  localparam logic [3:0]  DRAIN_INIT = 4'(FLUSH_CYCLES - 1);
  localparam logic [31:0] IRQ_CAUSE  = 32'h8000_0009;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        kind_ret_q, kind_ret_d;
  logic [63:0] epc_q, epc_d;
  logic [31:0] cause_q, cause_d;
  logic        sie_q, sie_d;
  logic        spie_q, spie_d;
  logic [63:0] rpc_q, rpc_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      kind_ret_q <= 1'b0;
      epc_q      <= '0;
      cause_q    <= '0;
      sie_q      <= 1'b0;
      spie_q     <= 1'b0;
      rpc_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      kind_ret_q <= kind_ret_d;
      epc_q      <= epc_d;
      cause_q    <= cause_d;
      sie_q      <= sie_d;
      spie_q     <= spie_d;
      rpc_q      <= rpc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    kind_ret_d = kind_ret_q;
    epc_d      = epc_q;
    cause_d    = cause_q;
    sie_d      = sie_q;
    spie_d     = spie_q;
    rpc_d      = rpc_q;
    case (state_q)
      IDLE: begin
        // Fixed priority: exception, then SRET, then enabled interrupt.
        if (exc_valid) begin
          epc_d      = exc_pc;
          cause_d    = exc_cause;
          spie_d     = sie_q;
          sie_d      = 1'b0;
          kind_ret_d = 1'b0;
          cnt_d      = DRAIN_INIT;
          state_d    = DRAIN;
        end else if (sret_valid) begin
          sie_d      = spie_q;
          spie_d     = 1'b1;
          kind_ret_d = 1'b1;
          cnt_d      = DRAIN_INIT;
          state_d    = DRAIN;
        end else if (irq_pending && sie_q) begin
          epc_d      = irq_pc;
          cause_d    = IRQ_CAUSE;
          spie_d     = sie_q;
          sie_d      = 1'b0;
          kind_ret_d = 1'b0;
          cnt_d      = DRAIN_INIT;
          state_d    = DRAIN;
        end
      end
      DRAIN: begin
        if (cnt_q == 4'd0) begin
          if (kind_ret_q) begin
            rpc_d   = sepc_in;
            state_d = REDIRECT;
          end else begin
            state_d = WR_EPC;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WR_EPC:   state_d = WR_CAUSE;
      WR_CAUSE: begin
        rpc_d   = {stvec[63:2], 2'b00};
        state_d = REDIRECT;
      end
      REDIRECT: begin
        if (redirect_ready) state_d = IDLE;
      end
      default:  state_d = IDLE;
    endcase
  end

  // Outputs decode registered state only.
  always_comb begin
    flush          = (state_q == DRAIN);
    stall          = (state_q != IDLE);
    busy           = (state_q != IDLE);
    csr_we         = 1'b0;
    csr_addr       = 12'h000;
    csr_wdata      = 64'h0;
    redirect_valid = (state_q == REDIRECT);
    redirect_pc    = rpc_q;
    sie            = sie_q;
    if (state_q == WR_EPC) begin
      csr_we    = 1'b1;
      csr_addr  = CSR_SEPC;
      csr_wdata = epc_q;
    end else if (state_q == WR_CAUSE) begin
      csr_we    = 1'b1;
      csr_addr  = CSR_SCAUSE;
      csr_wdata = {32'b0, cause_q};
    end
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed table-driven bench for trap_sequencer with hand-written corner sequences.
module tb_trap_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        exc_valid;
  logic [31:0] exc_cause;
  logic [63:0] exc_pc;
  logic        irq_pending;
  logic [63:0] irq_pc;
  logic        sret_valid;
  logic [63:0] stvec;
  logic [63:0] sepc_in;
  logic        flush, stall, busy, csr_we;
  logic [11:0] csr_addr;
  logic [63:0] csr_wdata;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        redirect_ready;
  logic        sie;

  int checks = 0;
  int failures = 0;

  trap_sequencer #(.FLUSH_CYCLES(2), .CSR_SEPC(12'h141), .CSR_SCAUSE(12'h142)) dut (
    .clk(clk), .reset(reset),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc),
    .irq_pending(irq_pending), .irq_pc(irq_pc), .sret_valid(sret_valid),
    .stvec(stvec), .sepc_in(sepc_in),
    .flush(flush), .stall(stall), .busy(busy),
    .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready), .sie(sie)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        exc_v;
    logic [31:0] cause;
    logic [63:0] pc;
    logic [63:0] tvec;
    logic        rdy;
    logic        e_flush;
    logic        e_stall;
    logic        e_busy;
    logic        e_we;
    logic [11:0] e_addr;
    logic [63:0] e_wdata;
    logic        e_rv;
    logic [63:0] e_rpc;
    logic        e_sie;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue an SRET, check sie at accept, latency to redirect, target and return to IDLE.
  task automatic do_sret(input logic [63:0] epc, input logic exp_sie, input string tag);
    int n;
    sepc_in    = epc;
    sret_valid = 1'b1;
    tick();
    sret_valid = 1'b0;
    chk({tag, ".sie_at_accept"}, 64'(sie), 64'(exp_sie));
    n = 1;
    while (!redirect_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, ".latency"}, 64'(n), 64'd3);
    chk({tag, ".rpc"}, redirect_pc, epc);
    tick();
    chk({tag, ".idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    exc_valid = 0; exc_cause = 0; exc_pc = 0;
    irq_pending = 0; irq_pc = 0; sret_valid = 0;
    stvec = 0; sepc_in = 0; redirect_ready = 1'b1;

    //            exc cause  pc        tvec      rdy fl st bu we addr    wdata     rv rpc       sie
    vecs[0] = '{1'b1, 32'd2, 64'h1000, 64'h8003, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000, 64'h0,    1'b0, 64'h0,    1'b0};
    vecs[1] = '{1'b0, 32'd0, 64'h0,    64'h8003, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000, 64'h0,    1'b0, 64'h0,    1'b0};
    vecs[2] = '{1'b0, 32'd0, 64'h0,    64'h8003, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 12'h141, 64'h1000, 1'b0, 64'h0,    1'b0};
    vecs[3] = '{1'b0, 32'd0, 64'h0,    64'h8003, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 12'h142, 64'h2,    1'b0, 64'h0,    1'b0};
    vecs[4] = '{1'b0, 32'd0, 64'h0,    64'h8003, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 64'h0,    1'b1, 64'h8000, 1'b0};
    vecs[5] = '{1'b0, 32'd0, 64'h0,    64'h8003, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 64'h0,    1'b0, 64'h8000, 1'b0};

    #12;
    chk("rst.flush", 64'(flush), 64'd0);
    chk("rst.stall", 64'(stall), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.csr_we", 64'(csr_we), 64'd0);
    chk("rst.csr_addr", 64'(csr_addr), 64'd0);
    chk("rst.csr_wdata", csr_wdata, 64'd0);
    chk("rst.rv", 64'(redirect_valid), 64'd0);
    chk("rst.rpc", redirect_pc, 64'd0);
    chk("rst.sie", 64'(sie), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Basic exception trap, cycle by cycle.
    for (int i = 0; i < 6; i++) begin
      exc_valid = vecs[i].exc_v; exc_cause = vecs[i].cause; exc_pc = vecs[i].pc;
      stvec = vecs[i].tvec; redirect_ready = vecs[i].rdy;
      tick();
      chk($sformatf("v%0d.flush", i), 64'(flush), 64'(vecs[i].e_flush));
      chk($sformatf("v%0d.stall", i), 64'(stall), 64'(vecs[i].e_stall));
      chk($sformatf("v%0d.busy", i), 64'(busy), 64'(vecs[i].e_busy));
      chk($sformatf("v%0d.csr_we", i), 64'(csr_we), 64'(vecs[i].e_we));
      chk($sformatf("v%0d.csr_addr", i), 64'(csr_addr), 64'(vecs[i].e_addr));
      chk($sformatf("v%0d.csr_wdata", i), csr_wdata, vecs[i].e_wdata);
      chk($sformatf("v%0d.rv", i), 64'(redirect_valid), 64'(vecs[i].e_rv));
      chk($sformatf("v%0d.rpc", i), redirect_pc, vecs[i].e_rpc);
      chk($sformatf("v%0d.sie", i), 64'(sie), 64'(vecs[i].e_sie));
    end

    // Two SRETs bring sie to 1 (spie=0 then spie=1).
    do_sret(64'h700, 1'b0, "sret_a");
    do_sret(64'h704, 1'b1, "sret_b");

    // All three requests together: exception wins.
    exc_valid = 1; exc_cause = 32'd5; exc_pc = 64'h3000;
    sret_valid = 1; irq_pending = 1; irq_pc = 64'h9999; stvec = 64'hA002;
    tick();
    exc_valid = 0; sret_valid = 0; irq_pending = 0;
    chk("prio.sie", 64'(sie), 64'd0);
    chk("prio.busy", 64'(busy), 64'd1);
    tick(); tick();
    chk("prio.epc", csr_wdata, 64'h3000);
    tick();
    chk("prio.cause", csr_wdata, 64'h5);
    tick();
    chk("prio.rpc", redirect_pc, 64'hA000);
    tick();
    do_sret(64'h3000, 1'b1, "prio_ret");  // spie was 1

    // Enabled interrupt.
    irq_pending = 1; irq_pc = 64'h2004; stvec = 64'h8003;
    tick();
    irq_pending = 0;
    chk("irq.busy", 64'(busy), 64'd1);
    chk("irq.sie", 64'(sie), 64'd0);
    tick(); tick();
    chk("irq.epc_addr", 64'(csr_addr), 64'h141);
    chk("irq.epc", csr_wdata, 64'h2004);
    tick();
    chk("irq.cause_addr", 64'(csr_addr), 64'h142);
    chk("irq.cause", csr_wdata, 64'h0000_0000_8000_0009);
    tick();
    chk("irq.rpc", redirect_pc, 64'h8000);
    tick();
    do_sret(64'h2004, 1'b1, "irq_ret");

    // Redirect held off by ready=0; new exception during REDIRECT ignored.
    redirect_ready = 0;
    exc_valid = 1; exc_cause = 32'd7; exc_pc = 64'h4000; stvec = 64'h9001;
    tick();
    exc_valid = 0;
    tick(); tick(); tick(); tick();
    for (int k = 0; k < 3; k++) begin
      exc_valid = 1; exc_pc = 64'h5000;
      tick();
      chk($sformatf("hold%0d.rv", k), 64'(redirect_valid), 64'd1);
      chk($sformatf("hold%0d.rpc", k), redirect_pc, 64'h9000);
      chk($sformatf("hold%0d.we", k), 64'(csr_we), 64'd0);
    end
    // Leaving edge with exc_valid still high: not accepted on that edge.
    redirect_ready = 1;
    tick();
    chk("b2b.leave_busy", 64'(busy), 64'd0);
    chk("b2b.leave_rv", 64'(redirect_valid), 64'd0);
    tick();
    chk("b2b.accept_busy", 64'(busy), 64'd1);
    chk("b2b.accept_flush", 64'(flush), 64'd1);
    exc_valid = 0;
    tick(); tick();
    chk("b2b.epc", csr_wdata, 64'h5000);
    tick(); tick(); tick();
    chk("b2b.done", 64'(busy), 64'd0);

    // Asynchronous reset during WR_EPC.
    exc_valid = 1; exc_cause = 32'd3; exc_pc = 64'h6000;
    tick();
    exc_valid = 0;
    tick(); tick();
    chk("arst.pre_we", 64'(csr_we), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst.we", 64'(csr_we), 64'd0);
    chk("arst.stall", 64'(stall), 64'd0);
    chk("arst.busy", 64'(busy), 64'd0);
    chk("arst.sie", 64'(sie), 64'd0);
    chk("arst.addr", 64'(csr_addr), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    exc_valid = 1; exc_cause = 32'd4; exc_pc = 64'h6100;
    tick();
    exc_valid = 0;
    chk("arst.restart_flush", 64'(flush), 64'd1);
    tick(); tick();
    chk("arst.restart_epc", csr_wdata, 64'h6100);
    tick(); tick(); tick();
    chk("arst.restart_done", 64'(busy), 64'd0);

    // Interrupt pending with sie=0: never accepted.
    irq_pending = 1; irq_pc = 64'h7000;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("irq_masked%0d.busy", k), 64'(busy), 64'd0);
    end
    irq_pending = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trap_sequencer.md
# trap_sequencer

Supervisor trap controller between the exception detection logic and the pipeline/CSR file. It accepts exception, interrupt and SRET requests and arbitrates among them. For each accepted request it drains the pipeline, writes `sepc`/`scause` through the single CSR write port, updates the SIE/SPIE status bits, and hands the fetch stage a redirect PC over a valid/ready handshake.

## Interface
- `FLUSH_CYCLES`, default 2: number of cycles flush is held to drain the pipeline; legal range 1..15.
- `CSR_SEPC`, default 12'h141: CSR address written with the trapping PC.
- `CSR_SCAUSE`, default 12'h142: CSR address written with the cause.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `exc_valid`  in  1  synchronous exception request from the detection unit.
- `exc_cause`  in  32  exception cause; bit 31 must be 0.
- `exc_pc`  in  64  PC of the faulting instruction.
- `irq_pending`  in  1  supervisor external interrupt pending (level).
- `irq_pc`  in  64  PC of the next instruction to resume after the interrupt.
- `sret_valid`  in  1  SRET reached decode.
- `stvec`  in  64  current trap vector from the CSR file.
- `sepc_in`  in  64  current `sepc` from the CSR file.
- `flush`  out  1  kill all in-flight instructions.
- `stall`  out  1  freeze fetch/decode.
- `busy`  out  1  sequencer not IDLE.
- `csr_we`  out  1  CSR write strobe.
- `csr_addr`  out  12  CSR write address.
- `csr_wdata`  out  64  CSR write data.
- `redirect_valid`  out  1  new PC offered to fetch.
- `redirect_pc`  out  64  target PC.
- `redirect_ready`  in  1  fetch accepts the redirect.
- `sie`  out  1  supervisor interrupt enable.

## Operation
- FSM states: IDLE, DRAIN, WR_EPC, WR_CAUSE, REDIRECT.
- Arbitration is evaluated in IDLE only. Priority order: `exc_valid` > `sret_valid` > (`irq_pending` && `sie`). At most one request is accepted per edge.
- Exception accept: latch `exc_pc` into epc_q and `exc_cause` into cause_q. Set spie <= sie, sie <= 0. Set kind = TRAP.
- Interrupt accept: latch `irq_pc` into epc_q and 32'h8000_0009 into cause_q. Update spie/sie as for an exception. Set kind = TRAP.
- SRET accept: set sie <= spie, spie <= 1. Set kind = RET.
- IDLE -> DRAIN on accept. The drain counter loads FLUSH_CYCLES-1. DRAIN decrements each cycle and exits when the counter reaches 0.
- DRAIN -> WR_EPC if kind = TRAP; DRAIN -> REDIRECT if kind = RET.
- WR_EPC: `csr_we`=1, `csr_addr`=CSR_SEPC, `csr_wdata`=epc_q. Next state WR_CAUSE.
- WR_CAUSE: `csr_we`=1, `csr_addr`=CSR_SCAUSE, `csr_wdata`={32'b0, cause_q}. Next state REDIRECT.
- REDIRECT target:
  - TRAP: {stvec[63:2], 2'b00} (direct mode; low bits masked).
  - RET: `sepc_in` sampled on entry to REDIRECT.
- REDIRECT holds `redirect_valid`=1 with `redirect_pc` stable until `redirect_ready`=1, then returns to IDLE on that edge.
- `flush`=1 in DRAIN only. `stall`=1 in every non-IDLE state. `busy`=1 in every non-IDLE state.
- Requests arriving while busy are ignored and not queued; those instructions are flushed. Level `irq_pending` is re-evaluated in IDLE.
- All outputs are Moore decodes of state/registers; no combinational input-to-output path.
- When `csr_we`=0, `csr_addr` and `csr_wdata` drive 0.

## Timing
- Reset values: state IDLE, `flush`/`stall`/`busy`/`csr_we`/`redirect_valid` = 0, `csr_addr`=0, `csr_wdata`=0, `redirect_pc`=0, `sie`=0, spie=0, epc_q=0, cause_q=0, drain counter=0.
- Reset asserted mid-sequence forces IDLE and the reset values immediately, without waiting for a clock edge. A pending CSR write or redirect is abandoned.
- Trap latency is counted from the accept edge E0:
  - DRAIN occupies cycles E0..E(FLUSH_CYCLES-1).
  - WR_EPC follows at E(FLUSH_CYCLES).
  - WR_CAUSE follows at E(FLUSH_CYCLES+1).
  - `redirect_valid` first rises after E(FLUSH_CYCLES+2).
- SRET latency: `redirect_valid` rises after E(FLUSH_CYCLES).
- `sie` updates on the accept edge E0.
- Back-to-back: a request present on the edge that leaves REDIRECT is not accepted. The earliest new accept is the following edge.
- `redirect_ready` asserted while `redirect_valid`=0 has no effect.

## Test plan
- FLUSH_CYCLES=2, sie=0, `exc_valid` with cause=2 and pc=0x1000, `stvec`=0x8003, ready held 1 -> flush high 2 cycles; CSR 0x141<=0x1000; CSR 0x142<=2; redirect_pc=0x8000 one cycle; back to IDLE after 5 edges total.
- `exc_valid`, `sret_valid` and `irq_pending` asserted together with sie=1 -> exception path taken; sie=0 after E0, spie=1.
- sie=1, `irq_pending`=1, irq_pc=0x2004 -> scause write 0x0000_0000_8000_0009 and sepc write 0x2004. A following SRET with `sepc_in`=0x2004 -> redirect_pc=0x2004 and sie restored to 1.
- In REDIRECT, hold `redirect_ready`=0 for 3 cycles -> redirect_valid and redirect_pc stay stable; second exc_valid during those cycles is ignored and no extra CSR write occurs.
- Assert reset during WR_EPC -> csr_we, stall, busy and sie drop to 0 immediately; next exc_valid restarts cleanly from DRAIN.
- `irq_pending`=1 with sie=0 -> no accept, busy stays 0.
